// File: rtl/qsim_pkg.sv
// Shared word format, FSM encoding and helpers for the quantum-state sequencer.
// Words are sign-magnitude Q1.14: bit 15 sign, bits 14:0 magnitude with 14 fraction bits.
package qsim_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned FRAC_W = 14;

    typedef logic [WORD_W-1:0] qword_t;

    localparam qword_t ONE = 16'h4000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_GATE = 2'd1,
        COMPUTE   = 2'd2,
        RESULT    = 2'd3
    } qseq_state_e;

    // True when |w| > 1.0, ignoring the sign bit.
    function automatic logic mag_gt_one(qword_t w);
        return w[WORD_W-2:0] > ONE[WORD_W-2:0];
    endfunction

endpackage

// File: rtl/qstate_sequencer.sv
// Holds the 2^N-entry state vector, feeds {gate, state} to the downstream multiplier and writes
// the product back; presents the final state on a valid/ready port. Optional QSTATE_SAT_CHECK_EN.
module qstate_sequencer
    import qsim_pkg::*;
#(
    parameter int unsigned N       = 2,
    parameter int unsigned MUL_LAT = 1,
    localparam int unsigned VLEN   = 1 << N
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          init_valid,
    output logic                          init_ready,
    input  qword_t [VLEN-1:0]             init_state,
    input  logic                          gate_valid,
    output logic                          gate_ready,
    input  logic                          gate_last,
    input  qword_t [VLEN-1:0][VLEN-1:0]   gate,
    output qword_t [VLEN-1:0][VLEN-1:0]   mul_gate,
    output qword_t [VLEN-1:0]             mul_state,
    input  qword_t [VLEN-1:0]             mul_result,
    output logic                          res_valid,
    input  logic                          res_ready,
    output qword_t [VLEN-1:0]             res_state,
`ifdef QSTATE_SAT_CHECK_EN
    output logic                          sat_flag,
`endif
    output logic                          busy
);

    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

    qseq_state_e                 r_state;
    qseq_state_e                 w_next;
    logic                        w_init_fire;
    logic                        w_gate_fire;
    logic                        w_wb;
    logic                        w_res_fire;

    logic                        r_init_ready;
    logic                        r_gate_ready;
    logic                        r_res_valid;
    logic                        r_busy;
    logic                        r_last;
    logic [CNT_W-1:0]            r_cnt;
    qword_t [VLEN-1:0]           r_vec;
    qword_t [VLEN-1:0][VLEN-1:0] r_mul_gate;

    // Next-state decode; each transfer is qualified by the state that owns its ready.
    always_comb begin
        w_next      = r_state;
        w_init_fire = 1'b0;
        w_gate_fire = 1'b0;
        w_wb        = 1'b0;
        w_res_fire  = 1'b0;
        case (r_state)
            IDLE: begin
                if (init_valid) begin
                    w_init_fire = 1'b1;
                    w_next      = WAIT_GATE;
                end
            end
            WAIT_GATE: begin
                if (gate_valid) begin
                    w_gate_fire = 1'b1;
                    w_next      = COMPUTE;
                end
            end
            COMPUTE: begin
                if (r_cnt == '0) begin
                    w_wb   = 1'b1;
                    w_next = r_last ? RESULT : WAIT_GATE;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    w_res_fire = 1'b1;
                    w_next     = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_init_ready <= 1'b1;
            r_gate_ready <= 1'b0;
            r_res_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_init_ready <= (w_next == IDLE);
            r_gate_ready <= (w_next == WAIT_GATE);
            r_res_valid  <= (w_next == RESULT);
            r_busy       <= (w_next != IDLE);
        end
    end

    // State vector: loaded on init, overwritten by the product on writeback, else held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vec <= '0;
        end else if (w_init_fire) begin
            r_vec <= init_state;
        end else if (w_wb) begin
            r_vec <= mul_result;
        end
    end

    // Gate operand, last flag and multiplier wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mul_gate <= '0;
            r_last     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_gate_fire) begin
                r_mul_gate <= gate;
                r_last     <= gate_last;
                r_cnt      <= CNT_INIT;
            end else if ((r_state == COMPUTE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_res_fire) begin
                r_last <= 1'b0;
            end
        end
    end

`ifdef QSTATE_SAT_CHECK_EN
    logic w_sat_hit;
    logic r_sat_flag;

    always_comb begin
        w_sat_hit = 1'b0;
        for (int unsigned i = 0; i < VLEN; i++) begin
            if (mag_gt_one(mul_result[i])) begin
                w_sat_hit = 1'b1;
            end
        end
    end

    // Sticky until the next circuit is loaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat_flag <= 1'b0;
        end else if (w_init_fire) begin
            r_sat_flag <= 1'b0;
        end else if (w_wb && w_sat_hit) begin
            r_sat_flag <= 1'b1;
        end
    end

    assign sat_flag = r_sat_flag;
`endif

    assign init_ready = r_init_ready;
    assign gate_ready = r_gate_ready;
    assign res_valid  = r_res_valid;
    assign busy       = r_busy;
    assign mul_gate   = r_mul_gate;
    assign mul_state  = r_vec;
    assign res_state  = r_vec;

endmodule
